cpu: RTL and testbench

//  Top-level 8-bit processor for the reciprocal program.
//  - Reads a 16-bit divisor d from data memory and computes floor(2^15/d) in 16 bits.
//  - The result is bits [63:48] of 2^63/d, a Q1.15 value of 1/d.
//  - Writes the result back to data memory and raises Ack.
//  - A hardwired FSM drives an 8x8 register file and a byte-wide data memory.

---
 rtl/cpu_pkg.sv | 46 ++++
 rtl/data_mem.sv | 31 +++
 rtl/reg_file.sv | 32 +++
 rtl/cpu.sv | 184 ++++++++++++++++++
 tb/tb_cpu.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the reciprocal CPU.
//   - state_t   : controller states (ROUND is only reachable when RECIP_ROUND_EN is defined)
//   - DM_DEPTH, DIVISOR_ADDR, RESULT_ADDR : data memory geometry and operand/result locations
//   - R_*       : register file slot assignment used by the divide program
//   - div_step  : one restoring-division step (17-bit compare)
package cpu_pkg;

  localparam int         DM_DEPTH     = 256;
  localparam logic [7:0] DIVISOR_ADDR = 8'd8;
  localparam logic [7:0] RESULT_ADDR  = 8'd10;

  localparam logic [2:0] R_DHI  = 3'd0;
  localparam logic [2:0] R_DLO  = 3'd1;
  localparam logic [2:0] R_RHI  = 3'd2;
  localparam logic [2:0] R_RLO  = 3'd3;
  localparam logic [2:0] R_QHI  = 3'd4;
  localparam logic [2:0] R_QLO  = 3'd5;
  localparam logic [2:0] R_CNT  = 3'd6;
  localparam logic [2:0] R_STAT = 3'd7;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_HI  = 3'd1,
    LOAD_LO  = 3'd2,
    DIV      = 3'd3,
    ROUND    = 3'd4,
    STORE_HI = 3'd5,
    STORE_LO = 3'd6,
    DONE     = 3'd7
  } state_t;

  // Returns {q_bit, new_remainder}. The remainder after a successful
  // subtract is always < d, so it fits in 16 bits; with d=0 the compare
  // always succeeds, which is what saturates the quotient to all ones.
  function automatic logic [16:0] div_step(input logic [15:0] rem,
                                           input logic        din,
                                           input logic [15:0] dvsr);
    logic [16:0] rem17;
    logic [16:0] diff;
    rem17 = {rem, din};
    diff  = rem17 - {1'b0, dvsr};
    if (rem17 >= {1'b0, dvsr}) return {1'b1, diff[15:0]};
    else                       return {1'b0, rem17[15:0]};
  endfunction

endpackage

// File: rtl/data_mem.sv
// data_mem: byte-wide data memory, one synchronous write port and two
// asynchronous read ports. Contents are never reset; the bench preloads them.
//   clk_i            : clock
//   we_i/waddr_i/wdata_i : write port
//   raddr0_i/rdata0_o    : read port 0
//   raddr1_i/rdata1_o    : read port 1
module data_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr0_i,
  output logic [7:0]    rdata0_o,
  input  logic [AW-1:0] raddr1_i,
  output logic [7:0]    rdata1_o
);

  reg [7:0] Core [0:DEPTH-1];

  // Plain always block: the array is also written by bench backdoor access.
  always @(posedge clk_i) begin
    if (we_i) Core[waddr_i] <= wdata_i;
  end

  assign rdata0_o = Core[raddr0_i];
  assign rdata1_o = Core[raddr1_i];

endmodule

// File: rtl/reg_file.sv
// reg_file: 8 x 8-bit register file, synchronous write with a per-register
// enable (the divide step updates several registers in one cycle),
// asynchronous read of all registers, synchronous clear on rst_i.
//   clk_i, rst_i : clock, synchronous active-high reset
//   we_i[i]      : write enable for register i
//   wdata_i[i]   : write data for register i
//   rdata_o[i]   : current value of register i
module reg_file (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [7:0]      we_i,
  input  logic [7:0][7:0] wdata_i,
  output logic [7:0][7:0] rdata_o
);

  reg [7:0] Registers [0:7];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 8; i++) Registers[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (we_i[i]) Registers[i] <= wdata_i[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) rdata_o[i] = Registers[i];
  end

endmodule

// File: rtl/cpu.sv
// cpu: hardwired reciprocal processor. Reads divisor d from Core[8..9],
// computes floor(2^15/d) by 16 restoring-division steps held in the
// register file, writes the result to Core[10..11] and raises Ack.
//   Clk   : clock
//   Reset : synchronous active-high reset
//   Start : high arms the CPU; first edge seeing it low launches the run;
//           high while in DONE returns to IDLE (armed)
//   Ack   : registered, high only in DONE
// Optional feature macro RECIP_ROUND_EN: adds a ROUND state that computes one
// extra quotient bit and rounds the result half-LSB upward (saturating).
module cpu
  import cpu_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  output logic Ack
);

  state_t state_q, state_d;
  logic   armed_q, armed_d;
  logic   ack_q,   ack_d;

  logic [7:0]      rf_we;
  logic [7:0][7:0] rf_wdata;
  logic [7:0][7:0] rf_rdata;

  logic       dm_we;
  logic [7:0] dm_waddr, dm_wdata, dm_rdata0, dm_rdata1;

  reg_file RF1 (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .we_i    (rf_we),
    .wdata_i (rf_wdata),
    .rdata_o (rf_rdata)
  );

  data_mem #(.DEPTH(DM_DEPTH)) DM1 (
    .clk_i    (Clk),
    .we_i     (dm_we),
    .waddr_i  (dm_waddr),
    .wdata_i  (dm_wdata),
    .raddr0_i (DIVISOR_ADDR),
    .rdata0_o (dm_rdata0),
    .raddr1_i (DIVISOR_ADDR + 8'd1),
    .rdata1_o (dm_rdata1)
  );

  // Divide datapath
  logic [15:0] dvsr, rem, quo, rem_nxt, quo_rnd;
  logic [7:0]  cnt;
  logic        din_bit, qbit;
  logic [16:0] step;

  assign dvsr = {rf_rdata[R_DHI], rf_rdata[R_DLO]};
  assign rem  = {rf_rdata[R_RHI], rf_rdata[R_RLO]};
  assign quo  = {rf_rdata[R_QHI], rf_rdata[R_QLO]};
  assign cnt  = rf_rdata[R_CNT];

  // Dividend 16'h8000 shifted MSB first: only the first step (count 16)
  // brings in a 1. The ROUND step brings in a 0, giving q[-1].
  assign din_bit = (state_q == DIV) && (cnt == 8'd16);
  assign step    = div_step(rem, din_bit, dvsr);
  assign qbit    = step[16];
  assign rem_nxt = step[15:0];
  assign quo_rnd = (qbit && (quo != 16'hFFFF)) ? quo + 16'd1 : quo;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      ack_q   <= ack_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
          state_d = LOAD_HI;
        end
      end
      LOAD_HI: state_d = LOAD_LO;
      LOAD_LO: state_d = DIV;
      DIV: begin
        if (cnt == 8'd1) begin
`ifdef RECIP_ROUND_EN
          state_d = ROUND;
`else
          state_d = STORE_HI;
`endif
        end
      end
      ROUND:    state_d = STORE_HI;
      STORE_HI: state_d = STORE_LO;
      STORE_LO: state_d = DONE;
      DONE: begin
        if (Start) begin
          state_d = IDLE;
          armed_d = 1'b1;
        end
      end
      default:  state_d = IDLE;
    endcase
    ack_d = (state_d == DONE);
  end

  // Output / datapath control
  always_comb begin
    rf_we    = 8'h00;
    rf_wdata = '0;
    dm_we    = 1'b0;
    dm_waddr = RESULT_ADDR;
    dm_wdata = 8'h00;
    unique case (state_q)
      LOAD_HI: begin
        rf_we[R_DHI]    = 1'b1;
        rf_wdata[R_DHI] = dm_rdata0;
      end
      LOAD_LO: begin
        rf_we[R_DLO]    = 1'b1;
        rf_wdata[R_DLO] = dm_rdata1;
        rf_we[R_RHI]    = 1'b1;
        rf_we[R_RLO]    = 1'b1;
        rf_we[R_QHI]    = 1'b1;
        rf_we[R_QLO]    = 1'b1;
        rf_we[R_CNT]    = 1'b1;
        rf_wdata[R_CNT] = 8'd16;
      end
      DIV: begin
        rf_we[R_RHI]    = 1'b1;
        rf_wdata[R_RHI] = rem_nxt[15:8];
        rf_we[R_RLO]    = 1'b1;
        rf_wdata[R_RLO] = rem_nxt[7:0];
        rf_we[R_QHI]    = 1'b1;
        rf_wdata[R_QHI] = quo[14:7];
        rf_we[R_QLO]    = 1'b1;
        rf_wdata[R_QLO] = {quo[6:0], qbit};
        rf_we[R_CNT]    = 1'b1;
        rf_wdata[R_CNT] = cnt - 8'd1;
      end
`ifdef RECIP_ROUND_EN
      ROUND: begin
        rf_we[R_QHI]    = 1'b1;
        rf_wdata[R_QHI] = quo_rnd[15:8];
        rf_we[R_QLO]    = 1'b1;
        rf_wdata[R_QLO] = quo_rnd[7:0];
      end
`endif
      STORE_HI: begin
        dm_we    = 1'b1;
        dm_waddr = RESULT_ADDR;
        dm_wdata = rf_rdata[R_QHI];
      end
      STORE_LO: begin
        dm_we            = 1'b1;
        dm_waddr         = RESULT_ADDR + 8'd1;
        dm_wdata         = rf_rdata[R_QLO];
        rf_we[R_STAT]    = 1'b1;
        rf_wdata[R_STAT] = 8'h01;
      end
      default: ;
    endcase
  end

  assign Ack = ack_q;

  // quo_rnd only feeds the ROUND state when the rounding feature is built.
  logic unused_rnd;
  assign unused_rnd = ^quo_rnd;

endmodule

// File: tb/tb_cpu.sv
module tb_cpu;
  import cpu_pkg::*;

  logic Clk = 1'b0;
  logic Reset, Start, Ack;

  always #5 Clk = ~Clk;

  cpu dut (.Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack));

`ifdef RECIP_ROUND_EN
  localparam int LAT = 21;
`else
  localparam int LAT = 20;
`endif

  typedef struct {
    string       tag;
    logic [15:0] val;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] d);
    int unsigned q, r;
    if (d == 16'd0) return 16'hFFFF;
    q = 32768 / int'(d);
    r = 32768 % int'(d);
`ifdef RECIP_ROUND_EN
    if ((2 * r >= int'(d)) && (q < 65535)) q++;
`endif
    return q[15:0];
  endfunction

  // Wait for Ack, starting just before E0; returns edges counted after E0.
  task automatic wait_ack(output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge Clk); #1;
      if (Ack) begin
        lat = n - 1;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_run(input string tag, input logic [15:0] d, input bit with_reset);
    int  lat;
    bit  ok;
    sb_t e;
    if (with_reset) begin
      Reset = 1'b1;
      @(posedge Clk); #1;
      Reset = 1'b0;
    end
    Start = 1'b1;
    @(posedge Clk); #1;
    if (!with_reset) begin
      chk({tag, "_ack_drop"}, {31'd0, Ack}, 32'd0);
      chk({tag, "_idle"}, 32'(dut.state_q), 32'(IDLE));
    end
    @(posedge Clk); #1;
    dut.DM1.Core[8]  = d[15:8];
    dut.DM1.Core[9]  = d[7:0];
    dut.DM1.Core[10] = 8'h5A;
    dut.DM1.Core[11] = 8'hA5;
    sb_q.push_back('{tag, model(d)});
    Start = 1'b0;
    wait_ack(lat, ok);
    if (!ok) begin
      chk({tag, "_ack_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_latency"}, 32'(lat), 32'(LAT));
    end
    e = sb_q.pop_front();
    chk({e.tag, "_result"}, {16'd0, dut.DM1.Core[10], dut.DM1.Core[11]}, {16'd0, e.val});
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;

    chk("rst_ack", {31'd0, Ack}, 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    for (int i = 0; i < 8; i++)
      chk($sformatf("rst_R%0d", i), {24'd0, dut.RF1.Registers[i]}, 32'd0);

    do_run("d4", 16'h0004, 1'b1);
    do_run("d36", 16'd36, 1'b1);
    chk("d36_R7", {24'd0, dut.RF1.Registers[7]}, 32'h01);
    do_run("d1", 16'h0001, 1'b1);
    do_run("dFFFF", 16'hFFFF, 1'b1);
    do_run("d0", 16'h0000, 1'b1);

    // Abort a run with Reset at E10
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    Start = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    dut.DM1.Core[8] = 8'h00;
    dut.DM1.Core[9] = 8'h04;
    Start = 1'b0;
    @(posedge Clk);            // E0
    repeat (9) @(posedge Clk); // E1..E9
    #1;
    chk("abort_midrun_ack", {31'd0, Ack}, 32'd0);
    chk("abort_midrun_state", 32'(dut.state_q), 32'(DIV));
    Reset = 1'b1;
    @(posedge Clk); #1;        // E10
    Reset = 1'b0;
    chk("abort_ack", {31'd0, Ack}, 32'd0);
    chk("abort_state", 32'(dut.state_q), 32'(IDLE));
    repeat (25) @(posedge Clk);
    #1;
    chk("abort_ack_later", {31'd0, Ack}, 32'd0);
    chk("abort_state_later", 32'(dut.state_q), 32'(IDLE));
    do_run("rerun_d4", 16'h0004, 1'b1);

    // Start pulse while in DONE, then a second run without reset
    chk("done_before_pulse", {31'd0, Ack}, 32'd1);
    do_run("d3", 16'h0003, 1'b0);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
